// File: rtl/cnn_buffer_loader.sv
// Fills the IFmap/filter/psum buffers from one shared read port, round-robin among channels with words left and ready high.
// At least 4 cycles per word (arb, fetch, capture, write); a write holds data and enable until the buffer takes it.
module cnn_buffer_loader #(
  parameter int IFMAP_BUFFER_WIDTH  = 18,
  parameter int FILTER_BUFFER_WIDTH = 16,
  parameter int PSUM_BUFFER_WIDTH   = 16,
  parameter int MEM_WIDTH           = 18,
  parameter int MEM_ADDR_WIDTH      = 10,
  parameter int COUNT_WIDTH         = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [MEM_ADDR_WIDTH-1:0]      if_base,
  input  logic [MEM_ADDR_WIDTH-1:0]      filter_base,
  input  logic [MEM_ADDR_WIDTH-1:0]      psum_base,
  input  logic [COUNT_WIDTH-1:0]         if_count,
  input  logic [COUNT_WIDTH-1:0]         filter_count,
  input  logic [COUNT_WIDTH-1:0]         psum_count,
  input  logic                           psum_en,
  output logic                           busy,
  output logic                           done,
  output logic                           mem_ren,
  output logic [MEM_ADDR_WIDTH-1:0]      mem_addr,
  input  logic [MEM_WIDTH-1:0]           mem_rdata,
  output logic [IFMAP_BUFFER_WIDTH-1:0]  IFmap_buffer_in,
  output logic                           IFmap_buffer_write_enable,
  input  logic                           IFmap_buffer_ready,
  output logic [FILTER_BUFFER_WIDTH-1:0] filter_buffer_in,
  output logic                           filter_buffer_write_enable,
  input  logic                           filter_buffer_ready,
  output logic [PSUM_BUFFER_WIDTH-1:0]   psum_buffer_in,
  output logic                           psum_buffer_wen,
  input  logic                           psum_buffer_ready
);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_FETCH, S_CAPTURE, S_WRITE, S_DONE} state_t;

  localparam logic [1:0] CH_IF     = 2'd0;
  localparam logic [1:0] CH_FILTER = 2'd1;
  localparam logic [1:0] CH_PSUM   = 2'd2;

  state_t                    state, state_nxt;
  logic [1:0]                grant;
  logic [1:0]                gnt_sel;
  logic                      gnt_vld;
  logic                      wr_rdy;
  logic                      all_zero;
  logic [3:0]                elig;
  logic [1:0]                cand [3];
  logic [MEM_ADDR_WIDTH-1:0] if_ptr, filter_ptr, psum_ptr, gnt_ptr;
  logic [COUNT_WIDTH-1:0]    if_rem, filter_rem, psum_rem;

  assign elig = {1'b0,
                 (psum_rem   != '0) && psum_buffer_ready,
                 (filter_rem != '0) && filter_buffer_ready,
                 (if_rem     != '0) && IFmap_buffer_ready};
  assign all_zero = (if_rem == '0) && (filter_rem == '0) && (psum_rem == '0);

  // grant holds the last-granted channel; search starts just after it
  always_comb begin
    cand[0] = CH_IF;
    cand[1] = CH_FILTER;
    cand[2] = CH_PSUM;
    case (grant)
      CH_IF: begin
        cand[0] = CH_FILTER;
        cand[1] = CH_PSUM;
        cand[2] = CH_IF;
      end
      CH_FILTER: begin
        cand[0] = CH_PSUM;
        cand[1] = CH_IF;
        cand[2] = CH_FILTER;
      end
      default: ;
    endcase
    gnt_vld = 1'b0;
    gnt_sel = cand[0];
    for (int k = 2; k >= 0; k--) begin
      if (elig[cand[k]]) begin
        gnt_vld = 1'b1;
        gnt_sel = cand[k];
      end
    end
  end

  always_comb begin
    case (gnt_sel)
      CH_IF:     gnt_ptr = if_ptr;
      CH_FILTER: gnt_ptr = filter_ptr;
      default:   gnt_ptr = psum_ptr;
    endcase
    case (grant)
      CH_IF:     wr_rdy = IFmap_buffer_ready;
      CH_FILTER: wr_rdy = filter_buffer_ready;
      default:   wr_rdy = psum_buffer_ready;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_ARB;
      S_ARB: begin
        if (all_zero)     state_nxt = S_DONE;
        else if (gnt_vld) state_nxt = S_FETCH;
      end
      S_FETCH:   state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_WRITE;
      S_WRITE:   if (wr_rdy) state_nxt = S_ARB;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy                       <= 1'b0;
      done                       <= 1'b0;
      mem_ren                    <= 1'b0;
      mem_addr                   <= '0;
      IFmap_buffer_in            <= '0;
      IFmap_buffer_write_enable  <= 1'b0;
      filter_buffer_in           <= '0;
      filter_buffer_write_enable <= 1'b0;
      psum_buffer_in             <= '0;
      psum_buffer_wen            <= 1'b0;
      grant                      <= CH_PSUM;
      if_ptr                     <= '0;
      filter_ptr                 <= '0;
      psum_ptr                   <= '0;
      if_rem                     <= '0;
      filter_rem                 <= '0;
      psum_rem                   <= '0;
    end else begin
      busy    <= state_nxt inside {S_ARB, S_FETCH, S_CAPTURE, S_WRITE};
      done    <= (state_nxt == S_DONE);
      mem_ren <= (state_nxt == S_FETCH);
      case (state)
        S_IDLE: begin
          if (start) begin
            if_ptr     <= if_base;
            filter_ptr <= filter_base;
            psum_ptr   <= psum_base;
            if_rem     <= if_count;
            filter_rem <= filter_count;
            psum_rem   <= psum_en ? psum_count : '0;
          end
        end
        S_ARB: begin
          if (gnt_vld) begin
            grant    <= gnt_sel;
            mem_addr <= gnt_ptr;
          end
        end
        S_CAPTURE: begin
          // read word arrives this cycle; narrower buffers keep the low bits
          case (grant)
            CH_IF: begin
              IFmap_buffer_in           <= mem_rdata[IFMAP_BUFFER_WIDTH-1:0];
              IFmap_buffer_write_enable <= 1'b1;
            end
            CH_FILTER: begin
              filter_buffer_in           <= mem_rdata[FILTER_BUFFER_WIDTH-1:0];
              filter_buffer_write_enable <= 1'b1;
            end
            default: begin
              psum_buffer_in  <= mem_rdata[PSUM_BUFFER_WIDTH-1:0];
              psum_buffer_wen <= 1'b1;
            end
          endcase
        end
        S_WRITE: begin
          if (wr_rdy) begin
            IFmap_buffer_write_enable  <= 1'b0;
            filter_buffer_write_enable <= 1'b0;
            psum_buffer_wen            <= 1'b0;
            case (grant)
              CH_IF: begin
                if_rem <= if_rem - COUNT_WIDTH'(1);
                if_ptr <= if_ptr + MEM_ADDR_WIDTH'(1);
              end
              CH_FILTER: begin
                filter_rem <= filter_rem - COUNT_WIDTH'(1);
                filter_ptr <= filter_ptr + MEM_ADDR_WIDTH'(1);
              end
              default: begin
                psum_rem <= psum_rem - COUNT_WIDTH'(1);
                psum_ptr <= psum_ptr + MEM_ADDR_WIDTH'(1);
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_buffer_loader.sv
// Directed bench for cnn_buffer_loader: vector table of whole jobs plus stall, busy-start, reset and blocked-channel sequences.
module tb_cnn_buffer_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  if_base = '0, filter_base = '0, psum_base = '0;
  logic [7:0]  if_count = '0, filter_count = '0, psum_count = '0;
  logic        psum_en = 1'b0;
  logic        busy, done, mem_ren;
  logic [9:0]  mem_addr;
  logic [17:0] mem_rdata = '0;
  logic [17:0] IFmap_buffer_in;
  logic        IFmap_buffer_write_enable;
  logic        IFmap_buffer_ready = 1'b1;
  logic [15:0] filter_buffer_in;
  logic        filter_buffer_write_enable;
  logic        filter_buffer_ready = 1'b1;
  logic [15:0] psum_buffer_in;
  logic        psum_buffer_wen;
  logic        psum_buffer_ready = 1'b1;

  cnn_buffer_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .if_base(if_base), .filter_base(filter_base), .psum_base(psum_base),
    .if_count(if_count), .filter_count(filter_count), .psum_count(psum_count),
    .psum_en(psum_en), .busy(busy), .done(done),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .IFmap_buffer_in(IFmap_buffer_in), .IFmap_buffer_write_enable(IFmap_buffer_write_enable),
    .IFmap_buffer_ready(IFmap_buffer_ready),
    .filter_buffer_in(filter_buffer_in), .filter_buffer_write_enable(filter_buffer_write_enable),
    .filter_buffer_ready(filter_buffer_ready),
    .psum_buffer_in(psum_buffer_in), .psum_buffer_wen(psum_buffer_wen),
    .psum_buffer_ready(psum_buffer_ready)
  );

  always #5 clk = ~clk;

  logic [17:0] mem [1024];
  always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

  // accepted writes as {channel, zero-extended data}; issued read addresses
  logic [19:0] wr_q [$];
  logic [9:0]  ra_q [$];
  int wen_cycles = 0;
  int onehot_bad = 0;

  always @(posedge clk) begin
    if (!reset) begin
      if (mem_ren) ra_q.push_back(mem_addr);
      if (IFmap_buffer_write_enable && IFmap_buffer_ready) wr_q.push_back({2'd0, IFmap_buffer_in});
      if (filter_buffer_write_enable && filter_buffer_ready) wr_q.push_back({2'd1, 2'b00, filter_buffer_in});
      if (psum_buffer_wen && psum_buffer_ready) wr_q.push_back({2'd2, 2'b00, psum_buffer_in});
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      wen_cycles <= wen_cycles + int'(IFmap_buffer_write_enable) + int'(filter_buffer_write_enable) + int'(psum_buffer_wen);
      if (int'(IFmap_buffer_write_enable) + int'(filter_buffer_write_enable) + int'(psum_buffer_wen) > 1)
        onehot_bad <= onehot_bad + 1;
    end
  end

  typedef struct packed {
    logic [9:0]       ib;
    logic [7:0]       ic;
    logic [9:0]       fb;
    logic [7:0]       fc;
    logic [9:0]       pb;
    logic [7:0]       pc;
    logic             pe;
    logic [3:0]       nexp;
    logic [5:0][1:0]  exp_ch;
    logic [5:0][9:0]  exp_addr;
    logic [7:0]       dedge;
  } vec_t;

  vec_t vecs [6];

  int n_tests = 0;
  int n_fail = 0;
  int wbase, rbase, cbase;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mark();
    wbase = wr_q.size();
    rbase = ra_q.size();
    cbase = wen_cycles;
  endtask

  function automatic logic [19:0] wr_at(input int i);
    return (wbase + i < wr_q.size()) ? wr_q[wbase + i] : 20'hFFFFF;
  endfunction

  function automatic logic [9:0] rd_at(input int i);
    return (rbase + i < ra_q.size()) ? ra_q[rbase + i] : 10'h3FF;
  endfunction

  function automatic logic [19:0] exp_wr(input logic [1:0] ch, input logic [9:0] a);
    logic [17:0] w;
    w = mem[a];
    return (ch == 2'd0) ? {2'd0, w} : {ch, 2'b00, w[15:0]};
  endfunction

  task automatic start_job(input logic [9:0] ib, input logic [7:0] ic, input logic [9:0] fb,
                           input logic [7:0] fc, input logic [9:0] pb, input logic [7:0] pc,
                           input logic pe);
    @(negedge clk);
    if_base = ib; if_count = ic;
    filter_base = fb; filter_count = fc;
    psum_base = pb; psum_count = pc;
    psum_en = pe;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // k = number of rising edges after the start-sampling edge until done is seen
  task automatic wait_done(input int budget, output int k);
    k = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        k = c;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int found;
    int dcount;
    logic [1:0] ch;
    logic [9:0] a;

    for (int i = 0; i < 1024; i++) begin
      logic [9:0] ai;
      ai = 10'(i);
      mem[i] = {ai, ~ai[7:0]};
    end

    // per word 4 edges; done is raised one edge after the last write returns to ARB
    vecs[0] = '{10'd0, 8'd2, 10'd16, 8'd2, 10'd0, 8'd5, 1'b0, 4'd4,
                {2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0},
                {10'd0, 10'd16, 10'd1, 10'd17, 10'd0, 10'd0}, 8'd17};
    vecs[1] = '{10'd0, 8'd0, 10'd0, 8'd0, 10'd1023, 8'd3, 1'b1, 4'd3,
                {2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0},
                {10'd1023, 10'd0, 10'd1, 10'd0, 10'd0, 10'd0}, 8'd13};
    vecs[2] = '{10'd0, 8'd0, 10'd0, 8'd0, 10'd0, 8'd0, 1'b1, 4'd0,
                {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
                {10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0}, 8'd1};
    vecs[3] = '{10'd5, 8'd1, 10'd100, 8'd2, 10'd200, 8'd2, 1'b1, 4'd5,
                {2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd0},
                {10'd5, 10'd100, 10'd200, 10'd101, 10'd201, 10'd0}, 8'd21};
    vecs[4] = '{10'd1020, 8'd1, 10'd3, 8'd1, 10'd0, 8'd0, 1'b0, 4'd2,
                {2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0},
                {10'd1020, 10'd3, 10'd0, 10'd0, 10'd0, 10'd0}, 8'd9};
    // last grant was FILTER, so PSUM goes first
    vecs[5] = '{10'd7, 8'd1, 10'd8, 8'd1, 10'd9, 8'd1, 1'b1, 4'd3,
                {2'd2, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0},
                {10'd9, 10'd7, 10'd8, 10'd0, 10'd0, 10'd0}, 8'd13};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_ren", 32'(mem_ren), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_wens", 32'({IFmap_buffer_write_enable, filter_buffer_write_enable, psum_buffer_wen}), 32'd0);
    chk("rst_data", 32'(IFmap_buffer_in) | 32'(filter_buffer_in) | 32'(psum_buffer_in), 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      mark();
      start_job(vecs[v].ib, vecs[v].ic, vecs[v].fb, vecs[v].fc, vecs[v].pb, vecs[v].pc, vecs[v].pe);
      chk($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
      wait_done(200, k);
      chk($sformatf("v%0d_done_edge", v), 32'(k), 32'(vecs[v].dedge));
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", v), 32'({done, busy}), 32'd0);
      chk($sformatf("v%0d_nwrites", v), 32'(wr_q.size() - wbase), 32'(vecs[v].nexp));
      chk($sformatf("v%0d_nreads", v), 32'(ra_q.size() - rbase), 32'(vecs[v].nexp));
      chk($sformatf("v%0d_wen_cycles", v), 32'(wen_cycles - cbase), 32'(vecs[v].nexp));
      for (int i = 0; i < int'(vecs[v].nexp); i++) begin
        ch = vecs[v].exp_ch[5 - i];
        a  = vecs[v].exp_addr[5 - i];
        chk($sformatf("v%0d_addr%0d", v, i), 32'(rd_at(i)), 32'(a));
        chk($sformatf("v%0d_write%0d", v, i), 32'(wr_at(i)), 32'(exp_wr(ch, a)));
      end
      repeat (2) @(negedge clk);
    end

    // IFmap ready low through a 10-cycle write stall
    mem[0] = 18'h2A5F3;
    mark();
    start_job(10'd0, 8'd2, 10'd0, 8'd0, 10'd0, 8'd0, 1'b0);
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_ren) found = 1;
    end
    chk("stall_fetch_seen", 32'(found), 32'd1);
    IFmap_buffer_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("stall_hold%0d", c), 32'({IFmap_buffer_write_enable, IFmap_buffer_in}), 32'({1'b1, 18'h2A5F3}));
    end
    chk("stall_no_write", 32'(wr_q.size() - wbase), 32'd0);
    IFmap_buffer_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall_wen_drop", 32'(IFmap_buffer_write_enable), 32'd0);
    chk("stall_one_write", 32'(wr_q.size() - wbase), 32'd1);
    wait_done(30, k);
    chk("stall_done", 32'(k > 0), 32'd1);
    chk("stall_nwrites", 32'(wr_q.size() - wbase), 32'd2);
    chk("stall_word0", 32'(wr_at(0)), 32'({2'd0, 18'h2A5F3}));
    chk("stall_word1", 32'(wr_at(1)), 32'(exp_wr(2'd0, 10'd1)));

    // second start while busy must not disturb the running job
    mark();
    dcount = 0;
    start_job(10'd300, 8'd1, 10'd0, 8'd0, 10'd0, 8'd0, 1'b0);
    @(negedge clk);
    if_base = 10'd50;
    if_count = 8'd5;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (done) dcount++;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dcount++;
    end
    chk("busystart_done_count", 32'(dcount), 32'd1);
    chk("busystart_nwrites", 32'(wr_q.size() - wbase), 32'd1);
    chk("busystart_addr", 32'(rd_at(0)), 32'd300);
    chk("busystart_write", 32'(wr_at(0)), 32'(exp_wr(2'd0, 10'd300)));

    // asynchronous reset while the first write is pending
    mark();
    start_job(10'd8, 8'd4, 10'd0, 8'd0, 10'd0, 8'd0, 1'b0);
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (IFmap_buffer_write_enable) found = 1;
    end
    chk("rstmid_write_seen", 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_wen", 32'(IFmap_buffer_write_enable), 32'd0);
    chk("rstmid_busy_done", 32'({busy, done, mem_ren}), 32'd0);
    chk("rstmid_data", 32'(IFmap_buffer_in), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mark();
    start_job(10'd8, 8'd4, 10'd0, 8'd0, 10'd0, 8'd0, 1'b0);
    wait_done(100, k);
    chk("rstmid_rerun_done_edge", 32'(k), 32'd17);
    chk("rstmid_rerun_nwrites", 32'(wr_q.size() - wbase), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rstmid_rerun_addr%0d", i), 32'(rd_at(i)), 32'(8 + i));
      chk($sformatf("rstmid_rerun_write%0d", i), 32'(wr_at(i)), 32'(exp_wr(2'd0, 10'(8 + i))));
    end

    // filter never ready: IF words drain, then the job waits in ARB
    filter_buffer_ready = 1'b0;
    mark();
    dcount = 0;
    start_job(10'd20, 8'd3, 10'd40, 8'd1, 10'd0, 8'd0, 1'b0);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dcount++;
    end
    chk("blocked_no_done", 32'(dcount), 32'd0);
    chk("blocked_busy", 32'(busy), 32'd1);
    chk("blocked_nwrites", 32'(wr_q.size() - wbase), 32'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("blocked_if%0d", i), 32'(wr_at(i)), 32'(exp_wr(2'd0, 10'(20 + i))));
    filter_buffer_ready = 1'b1;
    wait_done(20, k);
    chk("blocked_done", 32'(k > 0), 32'd1);
    chk("blocked_total_writes", 32'(wr_q.size() - wbase), 32'd4);
    chk("blocked_filter_word", 32'(wr_at(3)), 32'(exp_wr(2'd1, 10'd40)));

    chk("wen_onehot", 32'(onehot_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
